// File: rtl/vx_dispatch_unit.sv
// vx_dispatch_unit
//   Arbitrates ISSUE_CNT dispatch streams round-robin onto a single
//   NUM_LANES-wide execute port. Each warp instruction is split into
//   THREAD_CNT/NUM_LANES lane packets. Packets whose thread-mask slice is empty
//   are skipped. Every packet carries pid/sop/eop so that the commit path can
//   rebuild the warp.
// Ports
//   clk, reset_n     clock, synchronous active-low reset
//   in_valid_i       per-slot request valid
//   in_ready_o       per-slot ack, pulses when the slot's last packet loads
//   in_hdr_i         per-slot opaque header
//   in_tmask_i       per-slot thread mask
//   in_rs_data_i     per-slot rs1/rs2/rs3 operands, [slot][rs][thread]
//   out_valid_o      packet valid (registered)
//   out_ready_i      execute unit accepts packet
//   out_isw_o        source issue slot
//   out_hdr_o        header, passed unchanged
//   out_tmask_o      thread-mask slice of this packet
//   out_rs_data_o    operand slice of this packet, [rs][lane]
//   out_pid_o        packet index (first thread = pid*NUM_LANES)
//   out_sop_o        first packet of the instruction
//   out_eop_o        last packet of the instruction
module vx_dispatch_unit #(
   parameter int unsigned ISSUE_CNT  = 4,
   parameter int unsigned THREAD_CNT = 4,
   parameter int unsigned NUM_LANES  = 4,
   parameter int unsigned XLEN       = 32,
   parameter int unsigned HDR_W      = 64,
   localparam int unsigned PID_COUNT = THREAD_CNT / NUM_LANES,
   localparam int unsigned PID_W     = (PID_COUNT > 1) ? $clog2(PID_COUNT) : 1,
   localparam int unsigned ISW_W     = (ISSUE_CNT > 1) ? $clog2(ISSUE_CNT) : 1
) (
   input  logic                               clk,
   input  logic                               reset_n,
   input  logic [ISSUE_CNT-1:0]               in_valid_i,
   output logic [ISSUE_CNT-1:0]               in_ready_o,
   input  logic [ISSUE_CNT*HDR_W-1:0]         in_hdr_i,
   input  logic [ISSUE_CNT*THREAD_CNT-1:0]    in_tmask_i,
   input  logic [ISSUE_CNT*3*THREAD_CNT*XLEN-1:0] in_rs_data_i,
   output logic                               out_valid_o,
   input  logic                               out_ready_i,
   output logic [ISW_W-1:0]                   out_isw_o,
   output logic [HDR_W-1:0]                   out_hdr_o,
   output logic [NUM_LANES-1:0]               out_tmask_o,
   output logic [3*NUM_LANES*XLEN-1:0]        out_rs_data_o,
   output logic [PID_W-1:0]                   out_pid_o,
   output logic                               out_sop_o,
   output logic                               out_eop_o
);

   localparam int unsigned SLOT_RS_W = 3 * THREAD_CNT * XLEN;
   localparam int unsigned OUT_RS_W  = 3 * NUM_LANES * XLEN;

   // control state
   logic                  out_valid_q, out_valid_d;
   logic                  lock_q, lock_d;
   logic [ISW_W-1:0]      sel_q, sel_d;
   logic [ISW_W-1:0]      rr_q, rr_d;
   logic [PID_W-1:0]      pid_cnt_q, pid_cnt_d;

   // output packet register
   logic [ISW_W-1:0]      isw_q;
   logic [HDR_W-1:0]      hdr_q;
   logic [NUM_LANES-1:0]  tmask_q;
   logic [OUT_RS_W-1:0]   rs_q;
   logic [PID_W-1:0]      pid_q;
   logic                  sop_q;
   logic                  eop_q;

   logic [ISW_W-1:0]      gnt_idx;
   logic                  gnt_any;
   logic [ISW_W-1:0]      slot;
   logic                  cur_valid;
   logic [THREAD_CNT-1:0] cur_tmask;
   logic [PID_COUNT-1:0]  slice_nz;
   logic [PID_W-1:0]      cand_pid;
   logic                  cand_found;
   logic                  more_above;
   logic [OUT_RS_W-1:0]   rs_slice;
   logic                  ld;
   logic                  fire;

   function automatic logic [ISW_W-1:0] slot_add(input logic [ISW_W-1:0] a, input int unsigned b);
      return ISW_W'((32'(a) + b) % ISSUE_CNT);
   endfunction

   // First valid slot at or after the round-robin pointer
   always_comb begin : arb
      gnt_idx = rr_q;
      gnt_any = 1'b0;
      for (int unsigned k = 0; k < ISSUE_CNT; k++) begin
         if (!gnt_any && in_valid_i[slot_add(rr_q, k)]) begin
            gnt_any = 1'b1;
            gnt_idx = slot_add(rr_q, k);
         end
      end
   end

   // Source slot: the locked slot, otherwise the fresh grant
   always_comb begin : src
      slot      = lock_q ? sel_q : gnt_idx;
      cur_valid = lock_q ? in_valid_i[sel_q] : gnt_any;
      cur_tmask = in_tmask_i[32'(slot)*THREAD_CNT +: THREAD_CNT];
      slice_nz  = '0;
      for (int unsigned p = 0; p < PID_COUNT; p++) begin
         slice_nz[p] = |cur_tmask[p*NUM_LANES +: NUM_LANES];
      end
   end

   // Lowest non-empty slice at/after the counter. An all-zero mask falls back to pid 0.
   // The packet is not the last one when any further non-empty slice lies above it.
   always_comb begin : walk
      cand_pid   = '0;
      cand_found = 1'b0;
      more_above = 1'b0;
      for (int unsigned p = 0; p < PID_COUNT; p++) begin
         if (slice_nz[p]) begin
            if (cand_found) begin
               more_above = 1'b1;
            end else if (p >= 32'(pid_cnt_q)) begin
               cand_found = 1'b1;
               cand_pid   = PID_W'(p);
            end
         end
      end
   end

   // Operand slice of the candidate packet, [rs][lane]
   always_comb begin : operand_slice
      rs_slice = '0;
      for (int unsigned r = 0; r < 3; r++) begin
         for (int unsigned l = 0; l < NUM_LANES; l++) begin
            rs_slice[(r*NUM_LANES + l)*XLEN +: XLEN] =
               in_rs_data_i[32'(slot)*SLOT_RS_W + (r*THREAD_CNT + 32'(cand_pid)*NUM_LANES + l)*XLEN +: XLEN];
         end
      end
   end

   // Next-state and ack. The ack is combinational so that it lines up with the eop load.
   always_comb begin : ctrl
      ld          = !out_valid_q || out_ready_i;
      fire        = ld && cur_valid;
      out_valid_d = out_valid_q;
      lock_d      = lock_q;
      sel_d       = sel_q;
      rr_d        = rr_q;
      pid_cnt_d   = pid_cnt_q;
      in_ready_o  = '0;
      if (ld) begin
         out_valid_d = cur_valid;
      end
      if (fire) begin
         if (more_above) begin
            lock_d    = 1'b1;
            sel_d     = slot;
            pid_cnt_d = cand_pid + PID_W'(1);
         end else begin
            lock_d    = 1'b0;
            pid_cnt_d = '0;
            rr_d      = slot_add(slot, 1);
            if (reset_n) begin
               in_ready_o = ISSUE_CNT'(1) << slot;
            end
         end
      end
   end

   // Control registers
   always_ff @(posedge clk) begin : ctrl_regs
      if (!reset_n) begin
         out_valid_q <= 1'b0;
         lock_q      <= 1'b0;
         sel_q       <= '0;
         rr_q        <= '0;
         pid_cnt_q   <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         lock_q      <= lock_d;
         sel_q       <= sel_d;
         rr_q        <= rr_d;
         pid_cnt_q   <= pid_cnt_d;
      end
   end

   // Packet payload; held while stalled
   always_ff @(posedge clk) begin : pkt_regs
      if (reset_n && fire) begin
         isw_q   <= slot;
         hdr_q   <= in_hdr_i[32'(slot)*HDR_W +: HDR_W];
         tmask_q <= cur_tmask[32'(cand_pid)*NUM_LANES +: NUM_LANES];
         rs_q    <= rs_slice;
         pid_q   <= cand_pid;
         sop_q   <= !lock_q;
         eop_q   <= !more_above;
      end
   end

   assign out_valid_o   = out_valid_q;
   assign out_isw_o     = isw_q;
   assign out_hdr_o     = hdr_q;
   assign out_tmask_o   = tmask_q;
   assign out_rs_data_o = rs_q;
   assign out_pid_o     = pid_q;
   assign out_sop_o     = sop_q;
   assign out_eop_o     = eop_q;

   // The upstream buffer must keep the locked slot valid until its ack
   locked_slot_valid_a : assert property (@(posedge clk) disable iff (!reset_n)
                                          lock_q |-> in_valid_i[sel_q]);

endmodule

// File: tb/tb_vx_dispatch_unit.sv
// Bench for vx_dispatch_unit with 4 slots, 8 threads and 2 lanes (4 packets per warp).
// A queue-based reference model predicts every output on every cycle.
// Directed sequences pin the model with literal values.
module tb_vx_dispatch_unit;
   localparam int unsigned IC  = 4;
   localparam int unsigned TC  = 8;
   localparam int unsigned NL  = 2;
   localparam int unsigned XL  = 32;
   localparam int unsigned HW  = 64;
   localparam int unsigned PC  = TC / NL;
   localparam int unsigned PW  = 2;
   localparam int unsigned IW  = 2;
   localparam int unsigned SRS = 3 * TC * XL;
   localparam int unsigned ORS = 3 * NL * XL;

   logic              clk = 1'b0;
   logic              reset_n;
   logic [IC-1:0]     in_valid;
   logic [IC-1:0]     in_ready;
   logic [IC*HW-1:0]  in_hdr;
   logic [IC*TC-1:0]  in_tmask;
   logic [IC*SRS-1:0] in_rs_data;
   logic              out_valid;
   logic              out_ready;
   logic [IW-1:0]     out_isw;
   logic [HW-1:0]     out_hdr;
   logic [NL-1:0]     out_tmask;
   logic [ORS-1:0]    out_rs_data;
   logic [PW-1:0]     out_pid;
   logic              out_sop;
   logic              out_eop;

   vx_dispatch_unit #(.ISSUE_CNT(IC), .THREAD_CNT(TC), .NUM_LANES(NL), .XLEN(XL), .HDR_W(HW)) dut (
      .clk(clk), .reset_n(reset_n),
      .in_valid_i(in_valid), .in_ready_o(in_ready), .in_hdr_i(in_hdr),
      .in_tmask_i(in_tmask), .in_rs_data_i(in_rs_data),
      .out_valid_o(out_valid), .out_ready_i(out_ready), .out_isw_o(out_isw),
      .out_hdr_o(out_hdr), .out_tmask_o(out_tmask), .out_rs_data_o(out_rs_data),
      .out_pid_o(out_pid), .out_sop_o(out_sop), .out_eop_o(out_eop));

   always #5 clk = ~clk;

   int unsigned total  = 0;
   int unsigned passed = 0;
   bit          chk_en = 1'b0;
   bit          rand_mode = 1'b0;
   logic [IC-1:0] acked;
   logic [IC-1:0] last_ack;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // ---------------- reference model ----------------
   bit            m_ov, m_lock, m_first, m_sop, m_eop, have;
   int unsigned   m_rr, m_slot, pk;
   int unsigned   m_pids[$];
   logic [IW-1:0] m_isw;
   logic [HW-1:0] m_hdr;
   logic [NL-1:0] m_tmask;
   logic [ORS-1:0] m_rs;
   logic [PW-1:0] m_pid;
   logic [IC-1:0] exp_rdy;

   always @(negedge clk) begin : model
      acked = in_ready;
      if (chk_en) begin
         chk("out_valid", out_valid, m_ov);
         if (m_ov) begin
            chk("out_isw", out_isw, m_isw);
            chk("out_hdr", out_hdr, m_hdr);
            chk("out_tmask", out_tmask, m_tmask);
            chk("out_rs_data", out_rs_data, m_rs);
            chk("out_pid", out_pid, m_pid);
            chk("out_sop", out_sop, m_sop);
            chk("out_eop", out_eop, m_eop);
         end
         exp_rdy = '0;
         if (!reset_n) begin
            m_ov = 1'b0; m_lock = 1'b0; m_rr = 0;
            m_pids.delete();
         end else if (!m_ov || out_ready) begin
            have = m_lock;
            if (!m_lock) begin
               for (int unsigned k = 0; k < IC; k++) begin
                  if (!have && in_valid[(m_rr + k) % IC]) begin
                     have   = 1'b1;
                     m_slot = (m_rr + k) % IC;
                     m_pids.delete();
                     for (int unsigned q = 0; q < PC; q++)
                        if (in_tmask[m_slot*TC + q*NL +: NL] != '0) m_pids.push_back(q);
                     if (m_pids.size() == 0) m_pids.push_back(0);
                     m_first = 1'b1;
                  end
               end
            end
            m_ov = have;
            if (have) begin
               pk      = m_pids.pop_front();
               m_isw   = IW'(m_slot);
               m_hdr   = in_hdr[m_slot*HW +: HW];
               m_tmask = in_tmask[m_slot*TC + pk*NL +: NL];
               for (int unsigned r = 0; r < 3; r++)
                  for (int unsigned l = 0; l < NL; l++)
                     m_rs[(r*NL + l)*XL +: XL] = in_rs_data[m_slot*SRS + (r*TC + pk*NL + l)*XL +: XL];
               m_pid   = PW'(pk);
               m_sop   = m_first;
               m_first = 1'b0;
               m_eop   = (m_pids.size() == 0);
               if (m_eop) begin
                  exp_rdy[m_slot] = 1'b1;
                  m_rr   = (m_slot + 1) % IC;
                  m_lock = 1'b0;
               end else begin
                  m_lock = 1'b1;
               end
            end
         end
         chk("in_ready", in_ready, exp_rdy);
      end
   end

   // ---------------- stimulus ----------------
   function automatic logic [TC-1:0] rand_tm();
      int unsigned r;
      r = $urandom_range(0, 7);
      if (r == 0) return '0;
      if (r == 1) return '1;
      return TC'($urandom);
   endfunction

   task automatic present(input int unsigned s, input logic [TC-1:0] tm);
      in_valid[s] = 1'b1;
      in_hdr[s*HW +: HW] = {$urandom, $urandom};
      in_tmask[s*TC +: TC] = tm;
      for (int unsigned i = 0; i < 3*TC; i++) in_rs_data[s*SRS + i*XL +: XL] = $urandom;
   endtask

   // Advance one cycle; retire slots the DUT acked; optionally refill idle slots
   task automatic step();
      @(posedge clk); #1;
      last_ack = acked;
      for (int unsigned s = 0; s < IC; s++) if (acked[s]) in_valid[s] = 1'b0;
      if (rand_mode)
         for (int unsigned s = 0; s < IC; s++)
            if (!in_valid[s] && $urandom_range(0, 99) < 30) present(s, rand_tm());
   endtask

   task automatic pkt(input string n, input int unsigned isw, input int unsigned pid,
                      input logic [NL-1:0] tm, input bit sop, input bit eop);
      chk({n, "_valid"}, out_valid, 1'b1);
      chk({n, "_isw"}, out_isw, IW'(isw));
      chk({n, "_pid"}, out_pid, PW'(pid));
      chk({n, "_tmask"}, out_tmask, tm);
      chk({n, "_sop"}, out_sop, sop);
      chk({n, "_eop"}, out_eop, eop);
   endtask

   int unsigned  exp_isw [5] = '{0, 1, 2, 3, 0};
   logic [HW-1:0] hold_hdr;
   bit            idle;

   initial begin
      reset_n = 1'b0; out_ready = 1'b1;
      in_valid = '0; in_hdr = '0; in_tmask = '0; in_rs_data = '0;
      acked = '0; last_ack = '0;
      repeat (3) @(posedge clk);
      #1; chk_en = 1'b1;
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_in_ready", in_ready, '0);
      reset_n = 1'b1;

      // sparse mask: packets at pid 0,2,3
      present(0, 8'b1101_0001);
      step(); pkt("sp0", 0, 0, 2'b01, 1, 0);
      step(); pkt("sp2", 0, 2, 2'b01, 0, 0);
      step(); pkt("sp3", 0, 3, 2'b11, 0, 1); chk("sp_ack", last_ack, 4'b0001);
      step(); chk("sp_idle", out_valid, 1'b0);

      // zero mask on slot 2
      present(2, 8'h00);
      step(); pkt("zm", 2, 0, 2'b00, 1, 1); chk("zm_ack", last_ack, 4'b0100);
      step(); chk("zm_idle", out_valid, 1'b0);

      // back-pressure mid-instruction
      present(1, 8'hFF);
      hold_hdr = in_hdr[1*HW +: HW];
      step(); pkt("bp0", 1, 0, 2'b11, 1, 0);
      step(); pkt("bp1", 1, 1, 2'b11, 0, 0);
      out_ready = 1'b0;
      repeat (5) begin
         step(); chk("bp_hold_pid", out_pid, 2'd1); chk("bp_hold_hdr", out_hdr, hold_hdr);
         chk("bp_hold_valid", out_valid, 1'b1);
      end
      out_ready = 1'b1;
      step(); pkt("bp2", 1, 2, 2'b11, 0, 0);
      step(); pkt("bp3", 1, 3, 2'b11, 0, 1);
      step(); chk("bp_idle", out_valid, 1'b0);

      // reset during pid 2; slot 0 must win afterwards and slot 2 restarts at pid 0
      present(2, 8'hFF);
      step(); step(); step(); pkt("rs2", 2, 2, 2'b11, 0, 0);
      reset_n = 1'b0;
      present(0, 8'b0000_0011);
      step(); chk("rs_valid", out_valid, 1'b0); chk("rs_in_ready", in_ready, '0);
      reset_n = 1'b1;
      step(); pkt("rs_s0", 0, 0, 2'b11, 1, 1); chk("rs_ack0", last_ack, 4'b0001);
      step(); pkt("rs_s2", 2, 0, 2'b11, 1, 0);
      repeat (4) step();
      chk("rs_drained", {out_valid, in_valid}, 5'b0);

      // all slots valid, one packet each: round-robin 0,1,2,3,0
      reset_n = 1'b0; step(); reset_n = 1'b1;
      for (int unsigned s = 0; s < IC; s++) present(s, 8'b0000_0010);
      for (int i = 0; i < 5; i++) begin
         step();
         chk("rr_isw", out_isw, IW'(exp_isw[i]));
         chk("rr_eop", out_eop, 1'b1);
         if (i == 0) present(0, 8'b0000_0010);
      end
      step(); chk("rr_idle", out_valid, 1'b0);

      // randomized traffic
      rand_mode = 1'b1;
      for (int c = 0; c < 4000; c++) begin
         out_ready = ($urandom_range(0, 9) < 7);
         reset_n   = ($urandom_range(0, 999) != 0);
         step();
      end

      // drain with a bounded budget
      rand_mode = 1'b0; out_ready = 1'b1; reset_n = 1'b1;
      idle = 1'b0;
      for (int c = 0; c < 200 && !idle; c++) begin
         step();
         idle = (in_valid == '0) && !out_valid;
      end
      chk("drain_done", idle, 1'b1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
